sparc_mem_responder: RTL

Memory-side responder for the SPARC datapath's memory port. It accepts requests issued from MAR/MDR (address, store data, load/store opcode, enable), models a 512-byte big-endian byte-addressable store with programmable wait states, and completes each transfer with a four-phase MFC handshake. Load data is returned sign- or zero-extended per the SPARC opcode. Misaligned accesses are flagged instead of performed.

---
 rtl/sparc_mem_responder.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/sparc_mem_responder.sv
// Memory-side responder for the SPARC memory port: 2^ADDR_BITS-byte big-endian store,
// programmable wait states, sign/zero-extended loads and a four-phase MFC handshake.
module sparc_mem_responder #(
    parameter int WAIT_STATES = 2,
    parameter int ADDR_BITS   = 9
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        RAM_enable,
    input  logic [5:0]  RAM_OpCode,
    input  logic [31:0] Address,
    input  logic [31:0] Data_In,
    output logic [31:0] Data_Out,
    output logic        MFC,
    output logic        Mem_Err,
    output logic        Busy,
    output logic [1:0]  dbg_state_o
);
    // Handshake: RAM_enable rises with a request and stays high until MFC is seen;
    // MFC (with Mem_Err) stays high until RAM_enable has been sampled low in DONE.
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_e;

    localparam int DEPTH = 1 << ADDR_BITS;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [5:0]            op_q, op_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           dout_q, dout_d;
    logic                  mfc_q, mfc_d;
    logic                  err_q, err_d;
    logic [7:0]            mem_q [DEPTH];

    logic [ADDR_BITS-1:0]  a1, a2, a3;
    logic [7:0]            b0, b1, b2, b3;
    logic                  is_load, is_store, signed_ld, illegal, misaligned, wr_en;
    logic [1:0]            size;      // 0 byte, 1 halfword, 2 word
    logic [31:0]           ld_data;
    logic                  unused_addr_hi;

    assign unused_addr_hi = ^Address[31:ADDR_BITS];

    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        signed_ld = 1'b0;
        size      = 2'd0;
        case (op_q)
            6'b000000: begin is_load = 1'b1; size = 2'd2; end
            6'b000001: begin is_load = 1'b1; size = 2'd0; end
            6'b000010: begin is_load = 1'b1; size = 2'd1; end
            6'b001001: begin is_load = 1'b1; size = 2'd0; signed_ld = 1'b1; end
            6'b001010: begin is_load = 1'b1; size = 2'd1; signed_ld = 1'b1; end
            6'b000100: begin is_store = 1'b1; size = 2'd2; end
            6'b000101: begin is_store = 1'b1; size = 2'd0; end
            6'b000110: begin is_store = 1'b1; size = 2'd1; end
            default: ;
        endcase
    end

    assign illegal    = !(is_load || is_store);
    assign misaligned = ((size == 2'd2) && (addr_q[1:0] != 2'b00)) ||
                        ((size == 2'd1) && addr_q[0]);

    assign a1 = addr_q + ADDR_BITS'(1);
    assign a2 = addr_q + ADDR_BITS'(2);
    assign a3 = addr_q + ADDR_BITS'(3);
    assign b0 = mem_q[addr_q];
    assign b1 = mem_q[a1];
    assign b2 = mem_q[a2];
    assign b3 = mem_q[a3];

    always_comb begin
        case (size)
            2'd0:    ld_data = {{24{signed_ld & b0[7]}}, b0};
            2'd1:    ld_data = {{16{signed_ld & b0[7]}}, b0, b1};
            default: ld_data = {b0, b1, b2, b3};
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        dout_d  = dout_q;
        mfc_d   = mfc_q;
        err_d   = err_q;
        wr_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (RAM_enable) begin
                    op_d    = RAM_OpCode;
                    addr_d  = Address[ADDR_BITS-1:0];
                    wdata_d = Data_In;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    mfc_d   = 1'b1;
                    err_d   = illegal || misaligned;
                    state_d = S_DONE;
                    if (!illegal && !misaligned) begin
                        if (is_load) dout_d = ld_data;
                        wr_en = is_store;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                if (!RAM_enable) begin
                    mfc_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 6'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            dout_q  <= 32'd0;
            mfc_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            dout_q  <= dout_d;
            mfc_q   <= mfc_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately not reset; reset forces IDLE, so wr_en cannot fire under Clr.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            case (size)
                2'd0: mem_q[addr_q] <= wdata_q[7:0];
                2'd1: begin
                    mem_q[addr_q] <= wdata_q[15:8];
                    mem_q[a1]     <= wdata_q[7:0];
                end
                default: begin
                    mem_q[addr_q] <= wdata_q[31:24];
                    mem_q[a1]     <= wdata_q[23:16];
                    mem_q[a2]     <= wdata_q[15:8];
                    mem_q[a3]     <= wdata_q[7:0];
                end
            endcase
        end
    end

    assign Data_Out    = dout_q;
    assign MFC         = mfc_q;
    assign Mem_Err     = err_q;
    assign Busy        = (state_q != S_IDLE);
    assign dbg_state_o = state_q;
endmodule
